// File: rtl/seq_pkg.sv
// Shared FSM encodings for the serial frame transmitter and the sequence detectors.
package seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_tx_if.sv
// Frame request / serial output bundle between a controller and seq_tx.
interface seq_tx_if
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);

  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   pattern;
  logic [LEN_W-1:0]   len;
  logic               w;
  logic               w_valid;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] state;

  modport master (
    output start, abort, pattern, len,
    input  w, w_valid, busy, done, state
  );

  modport slave (
    input  start, abort, pattern, len,
    output w, w_valid, busy, done, state
  );

endinterface

// File: rtl/seq_tx_piso_shift.sv
// Parallel-in/serial-out register with a saturating bit counter.
module piso_shift #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  input  logic [LEN_W-1:0] len,
  output logic             dout,
  output logic             last
);

  if (LEN_W < $clog2(WIDTH) + 1) begin : g_len_w_check
    $error("LEN_W too small for WIDTH");
  end

  logic [WIDTH-1:0] sr;
  logic [LEN_W-1:0] cnt;

  // Load frame (length clamped to WIDTH) or shift out MSB-first with zero fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= din;
      cnt <= (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
      if (cnt != '0) begin
        cnt <= cnt - LEN_W'(1);
      end
    end
  end

  assign dout = sr[WIDTH-1];
  assign last = (cnt == LEN_W'(1));

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: FSM and output decode around piso_shift.
module seq_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic    clk,
  input  logic    reset,
  seq_tx_if.slave bus
);

  state_t state, state_nx;
  logic   load, shift, dout, last;

  piso_shift #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (bus.pattern),
    .len   (bus.len),
    .dout  (dout),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and output decode; outputs depend on state only so reset clears them at once.
  always_comb begin
    state_nx    = IDLE;
    load        = 1'b0;
    shift       = 1'b0;
    bus.w       = 1'b0;
    bus.w_valid = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        bus.w       = dout;
        bus.w_valid = 1'b1;
        bus.busy    = 1'b1;
        shift       = 1'b1;
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (last) begin
          state_nx = DONE;
        end else begin
          state_nx = SHIFT;
        end
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.state = state;

endmodule
